// File: rtl/gamepad_event_ctrl_pkg.sv
// Shared definitions for the gamepad event controller: register map, STATUS
// bit positions, scan FSM encoding and the event byte layout.
package gamepad_event_ctrl_pkg;

  localparam int unsigned PAD_W  = 24;
  localparam int unsigned HALF_W = 12;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned EVT_W  = 8;
  localparam int unsigned IDX_W  = 5;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 6'h00;
  localparam logic [ADDR_W-1:0] ADDR_MASK   = 6'h04;
  localparam logic [ADDR_W-1:0] ADDR_EVENT  = 6'h08;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 6'h0C;
  localparam logic [ADDR_W-1:0] ADDR_STATE  = 6'h10;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;

  localparam int unsigned STAT_OVF_BIT   = 4;
  localparam int unsigned STAT_EMPTY_BIT = 5;
  localparam int unsigned STAT_SCAN_BIT  = 6;
  localparam int unsigned STAT_FLUSH_BIT = 7;

  localparam logic [1:0] ACC_NONE = 2'b11;
  localparam logic [1:0] ACC_B8   = 2'b00;
  localparam logic [1:0] ACC_H16  = 2'b01;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic       press;
    logic       ctrl;
    logic [1:0] rsvd;
    logic [3:0] idx;
  } event_t;

  // Byte-lane mask for an 8/16/32-bit write.
  function automatic logic [DATA_W-1:0] write_mask(input logic [1:0] size);
    case (size)
      ACC_B8:  write_mask = 32'h0000_00ff;
      ACC_H16: write_mask = 32'h0000_ffff;
      default: write_mask = 32'hffff_ffff;
    endcase
  endfunction

  // Build the event byte for a transition on global bit position pos (0-23).
  function automatic event_t make_event(input logic press, input logic [IDX_W-1:0] pos);
    make_event.press = press;
    make_event.ctrl  = (pos >= 5'd12);
    make_event.rsvd  = 2'b00;
    make_event.idx   = (pos >= 5'd12) ? 4'(pos - 5'd12) : 4'(pos);
  endfunction

endpackage

// File: rtl/gamepad_event_fifo.sv
// Event FIFO: power-of-two depth, flush has priority over push/pop, a push on
// a full FIFO succeeds when a pop happens in the same cycle.
// Ports: clk, rst_n (sync, active-low), push/din, pop, flush, full, empty,
// count (0..DEPTH), head (oldest entry).
module gamepad_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_pop;
  logic             do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: occupancy gates every observable entry.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/gamepad_event_ctrl.sv
// Gamepad event controller: compares each new pad frame against the last
// known state bit by bit and queues press/release events in a FIFO.
// Ports: clk, rst_n (sync, active-low), pad_state/pad_valid (frame input),
// address/data_in/data_write_n/data_read_n (register bus), data_out (read
// data), data_ready (always 1), user_interrupt (level).
module gamepad_event_ctrl
  import gamepad_event_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PAD_W-1:0]    pad_state,
  input  logic                pad_valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [1:0]          data_write_n,
  input  logic [1:0]          data_read_n,
  output logic [DATA_W-1:0]   data_out,
  output logic                data_ready,
  output logic                user_interrupt
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  scan_state_e        state;
  scan_state_e        state_nxt;
  logic               enable;
  logic               irq_en;
  logic [PAD_W-1:0]   mask;
  logic [PAD_W-1:0]   prev_state;
  logic [PAD_W-1:0]   scan_frame;
  logic [PAD_W-1:0]   pend_frame;
  logic               pend_valid;
  logic               armed;
  logic               overflow;
  logic [IDX_W-1:0]   bit_idx;

  logic               scan_active;
  logic               scan_last;
  logic               frame_start;
  logic               load_baseline;

  logic               wr_en;
  logic               rd_en;
  logic [DATA_W-1:0]  wmask;
  logic               wr_ctrl;
  logic               wr_mask;
  logic               wr_status;

  logic               cur_bit;
  logic [HALF_W-1:0]  cur_half;
  logic               present;
  logic               evt_push;
  event_t             evt;

  logic               fifo_pop;
  logic               fifo_flush;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [EVT_W-1:0]   fifo_head;
  logic               unused_ok;

  assign wr_en     = (data_write_n != ACC_NONE);
  assign rd_en     = (data_read_n != ACC_NONE);
  assign wmask     = write_mask(data_write_n);
  assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
  assign wr_mask   = wr_en && (address == ADDR_MASK);
  assign wr_status = wr_en && (address == ADDR_STATUS);

  assign fifo_pop   = rd_en && (address == ADDR_EVENT);
  assign fifo_flush = wr_status && data_in[STAT_FLUSH_BIT];

  // Bit under evaluation and presence of its controller in the scanned frame.
  assign cur_bit  = scan_frame[bit_idx];
  assign cur_half = (bit_idx >= 5'd12) ? scan_frame[23:12] : scan_frame[11:0];
  assign present  = (cur_half != 12'hfff);
  assign evt_push = scan_active && (cur_bit != prev_state[bit_idx]) && mask[bit_idx] && present;
  assign evt      = make_event(cur_bit, bit_idx);

  assign data_ready     = 1'b1;
  assign user_interrupt = irq_en & (~fifo_empty | overflow);
  assign unused_ok      = ^{data_in[31:24], wmask[31:24]};

  // Scan state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and scan control decode.
  always_comb begin
    state_nxt     = state;
    scan_active   = 1'b0;
    scan_last     = 1'b0;
    frame_start   = 1'b0;
    load_baseline = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && pad_valid) begin
          if (armed) begin
            load_baseline = 1'b1;
          end else begin
            frame_start = 1'b1;
            state_nxt   = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else begin
          scan_active = 1'b1;
          if (bit_idx == 5'd23) begin
            scan_last = 1'b1;
            if (!pad_valid && !pend_valid) state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control registers, frame tracking and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable     <= 1'b0;
      irq_en     <= 1'b0;
      mask       <= 24'hffffff;
      prev_state <= 24'hffffff;
      scan_frame <= '0;
      pend_frame <= '0;
      pend_valid <= 1'b0;
      armed      <= 1'b1;
      overflow   <= 1'b0;
      bit_idx    <= '0;
    end else begin
      if (wr_ctrl) begin
        enable <= data_in[CTRL_ENABLE_BIT];
        irq_en <= data_in[CTRL_IRQ_EN_BIT];
      end
      if (wr_mask) mask <= (mask & ~wmask[PAD_W-1:0]) | (data_in[PAD_W-1:0] & wmask[PAD_W-1:0]);

      // While disabled the next accepted frame becomes the new baseline.
      if (!enable) begin
        armed      <= 1'b1;
        pend_valid <= 1'b0;
      end
      if (load_baseline) begin
        prev_state <= pad_state;
        armed      <= 1'b0;
      end

      if (frame_start) begin
        scan_frame <= pad_state;
        bit_idx    <= '0;
      end else if (scan_active) begin
        prev_state[bit_idx] <= cur_bit;
        if (scan_last) begin
          bit_idx    <= '0;
          pend_valid <= 1'b0;
          if (pad_valid)       scan_frame <= pad_state;
          else if (pend_valid) scan_frame <= pend_frame;
        end else begin
          bit_idx <= bit_idx + IDX_W'(1);
          if (pad_valid) begin
            pend_frame <= pad_state;
            pend_valid <= 1'b1;
          end
        end
      end

      if (wr_status && data_in[STAT_OVF_BIT]) overflow <= 1'b0;
      if (evt_push && fifo_full && !fifo_pop && !fifo_flush) overflow <= 1'b1;
    end
  end

  // Register read mux; an empty EVENT read returns zero.
  always_comb begin
    data_out = '0;
    case (address)
      ADDR_CTRL:   data_out = {30'h0, irq_en, enable};
      ADDR_MASK:   data_out = {8'h0, mask};
      ADDR_EVENT:  data_out = fifo_empty ? 32'h0 : {23'h0, 1'b1, fifo_head};
      ADDR_STATUS: data_out = {25'h0, (state == ST_SCAN), fifo_empty, overflow, 4'(fifo_count)};
      ADDR_STATE:  data_out = {8'h0, prev_state};
      default:     data_out = '0;
    endcase
  end

  gamepad_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (evt_push),
    .din   (evt),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

endmodule
